// File: rtl/rggen_rtl_pkg.sv
// Shared bus-level types for the register-bus fabric: response status
// codes and access direction, used by both bus interfaces and the splitter.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

endpackage

// File: rtl/rggen_bus_if.sv
// Upstream register bus: a request/done handshake carrying one access.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);

  logic                                request;
  logic [ADDRESS_WIDTH-1:0]            address;
  rggen_rtl_pkg::rggen_direction       direction;
  logic [DATA_WIDTH-1:0]               write_data;
  logic [DATA_WIDTH/8-1:0]             write_strobe;
  logic                                done;
  logic [DATA_WIDTH-1:0]               read_data;
  rggen_rtl_pkg::rggen_status          status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_data, status
  );

endinterface

// File: rtl/rggen_register_if.sv
// Per-register channel: the splitter broadcasts the access, each register
// answers with its address-decode select, ready, read data and status.
interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);

  logic                                request;
  logic [ADDRESS_WIDTH-1:0]            address;
  rggen_rtl_pkg::rggen_direction       direction;
  logic [DATA_WIDTH-1:0]               write_data;
  logic [DATA_WIDTH/8-1:0]             write_strobe;
  logic                                select;
  logic                                ready;
  logic [DATA_WIDTH-1:0]               read_data;
  rggen_rtl_pkg::rggen_status          status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  select, ready, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output select, ready, read_data, status
  );

endinterface

// File: rtl/rggen_or_mux.sv
// One-hot OR-mux: ORs together every entry whose select bit is set.
// With a true one-hot select this is a plain mux; with several selects it
// yields the bitwise OR of the chosen entries.
module rggen_or_mux #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 2
) (
  input  logic [ENTRIES-1:0]            select_i,
  input  logic [ENTRIES-1:0][WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]              data_o
);

  // Accumulate the selected entries.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    data_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (select_i[i]) begin
        data_o = data_o | data_i[i];
      end
    end
  end

endmodule

// File: rtl/rggen_bus_splitter_ex.sv
// Register bus splitter: fans one upstream access out to TOTAL_REGISTERS
// register channels, waits for the selected register (or an error or
// timeout condition), and returns a single registered response.
module rggen_bus_splitter_ex #(
  parameter int DATA_WIDTH         = 32,
  parameter int TOTAL_REGISTERS    = 1,
  parameter int TIMEOUT_CYCLES     = 0,
  parameter int CHECK_MULTI_SELECT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rggen_bus_if.slave              bus_if,
  rggen_register_if.master        register_if [TOTAL_REGISTERS],
  output logic [$clog2((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES + 1 : 2)-1:0] timeout_count
);

  import rggen_rtl_pkg::*;

  localparam int CW = $clog2((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES + 1 : 2);

  localparam logic [0:0] ACCESS   = 1'b0;
  localparam logic [0:0] RESPONSE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  rggen_status           status_q, status_d;

  logic [TOTAL_REGISTERS-1:0]                 select;
  logic [TOTAL_REGISTERS-1:0]                 ready;
  logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0] read_data_all;
  logic [TOTAL_REGISTERS-1:0][1:0]            status_all;
  logic [DATA_WIDTH-1:0]                      mux_read_data;
  logic [1:0]                                 mux_status;

  logic                  in_access;
  logic                  no_select;
  logic                  multi_select;
  logic                  ready_any;
  logic                  timeout_hit;
  logic                  complete;
  logic [DATA_WIDTH-1:0] resp_data;
  rggen_status           resp_status;

  assign in_access = (state_q == ACCESS);

  // Broadcast the access to every channel and gather the fan-in signals.
  for (genvar g = 0; g < TOTAL_REGISTERS; g++) begin : g_channel
    assign register_if[g].request      = bus_if.request && in_access;
    assign register_if[g].address      = bus_if.address;
    assign register_if[g].direction    = bus_if.direction;
    assign register_if[g].write_data   = bus_if.write_data;
    assign register_if[g].write_strobe = bus_if.write_strobe;
    assign select[g]        = register_if[g].select;
    assign ready[g]         = register_if[g].ready;
    assign read_data_all[g] = register_if[g].read_data;
    assign status_all[g]    = register_if[g].status;
  end

  rggen_or_mux #(
    .WIDTH   (DATA_WIDTH),
    .ENTRIES (TOTAL_REGISTERS)
  ) u_read_data_mux (
    .select_i (select),
    .data_i   (read_data_all),
    .data_o   (mux_read_data)
  );

  rggen_or_mux #(
    .WIDTH   (2),
    .ENTRIES (TOTAL_REGISTERS)
  ) u_status_mux (
    .select_i (select),
    .data_i   (status_all),
    .data_o   (mux_status)
  );

  // Completion conditions; a lone select bit clears when ANDed with itself minus one.
  assign no_select    = (select == '0);
  assign multi_select = (CHECK_MULTI_SELECT != 0) &&
                        ((select & (select - TOTAL_REGISTERS'(1))) != '0);
  assign ready_any    = |(select & ready);
  assign timeout_hit  = (TIMEOUT_CYCLES > 0) && (count_q == CW'(TIMEOUT_CYCLES - 1));
  assign complete     = bus_if.request && (no_select || multi_select || ready_any || timeout_hit);

  // Prioritised response: decode error, multi-select error, register answer, timeout.
  always_comb begin
    resp_data   = '0;
    resp_status = RGGEN_OKAY;
    if (no_select) begin
      resp_status = RGGEN_DECODE_ERROR;
    end else if (multi_select) begin
      resp_status = RGGEN_SLAVE_ERROR;
    end else if (ready_any) begin
      resp_status = rggen_status'(mux_status);
      if (bus_if.direction == RGGEN_READ) begin
        resp_data = mux_read_data;
      end
    end else begin
      resp_status = RGGEN_SLAVE_ERROR;
    end
  end

  // Next state: capture the response on completion, count wait cycles otherwise.
  always_comb begin
    state_d     = state_q;
    count_d     = '0;
    read_data_d = '0;
    status_d    = RGGEN_OKAY;
    if (state_q == ACCESS) begin
      if (complete) begin
        state_d     = RESPONSE;
        read_data_d = resp_data;
        status_d    = resp_status;
      end else if (bus_if.request && (TIMEOUT_CYCLES > 0)) begin
        count_d = count_q + CW'(1);
      end
    end else begin
      state_d = ACCESS;
    end
  end

  // State, wait counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCESS;
      count_q     <= '0;
      read_data_q <= '0;
      status_q    <= RGGEN_OKAY;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      status_q    <= status_d;
    end
  end

  assign bus_if.done      = (state_q == RESPONSE);
  assign bus_if.read_data = read_data_q;
  assign bus_if.status    = status_q;
  assign timeout_count    = count_q;

endmodule

// File: tb/tb_rggen_bus_splitter_ex.sv
// Directed bench for the bus splitter. Two instances share one stimulus:
// dut_a with a 4-cycle timeout and multi-select checking, dut_b with no
// timeout and multi-select checking disabled.
module tb_rggen_bus_splitter_ex;

  import rggen_rtl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Shared upstream stimulus.
  logic           req;
  logic [15:0]    addr;
  rggen_direction dir;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;

  // Shared register-side responses.
  logic [2:0]       sel;
  logic [2:0]       rdy;
  logic [2:0][31:0] rdata;
  logic [2:0][1:0]  stat;

  // Probes.
  logic [2:0]     req_a, req_b;
  logic [15:0]    addr_a1;
  rggen_direction dir_a0;
  logic [31:0]    wdata_a2;
  logic [3:0]     wstrb_a2;
  logic [2:0]     tcnt_a;
  logic [0:0]     tcnt_b;

  int checks   = 0;
  int failures = 0;

  rggen_bus_if      bus_a ();
  rggen_bus_if      bus_b ();
  rggen_register_if reg_a [3] ();
  rggen_register_if reg_b [3] ();

  assign bus_a.request      = req;
  assign bus_a.address      = addr;
  assign bus_a.direction    = dir;
  assign bus_a.write_data   = wdata;
  assign bus_a.write_strobe = wstrb;
  assign bus_b.request      = req;
  assign bus_b.address      = addr;
  assign bus_b.direction    = dir;
  assign bus_b.write_data   = wdata;
  assign bus_b.write_strobe = wstrb;

  for (genvar g = 0; g < 3; g++) begin : g_regs
    assign reg_a[g].select    = sel[g];
    assign reg_a[g].ready     = rdy[g];
    assign reg_a[g].read_data = rdata[g];
    assign reg_a[g].status    = rggen_status'(stat[g]);
    assign reg_b[g].select    = sel[g];
    assign reg_b[g].ready     = rdy[g];
    assign reg_b[g].read_data = rdata[g];
    assign reg_b[g].status    = rggen_status'(stat[g]);
    assign req_a[g]           = reg_a[g].request;
    assign req_b[g]           = reg_b[g].request;
  end

  assign addr_a1  = reg_a[1].address;
  assign dir_a0   = reg_a[0].direction;
  assign wdata_a2 = reg_a[2].write_data;
  assign wstrb_a2 = reg_a[2].write_strobe;

  rggen_bus_splitter_ex #(
    .DATA_WIDTH         (32),
    .TOTAL_REGISTERS    (3),
    .TIMEOUT_CYCLES     (4),
    .CHECK_MULTI_SELECT (1)
  ) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_if        (bus_a),
    .register_if   (reg_a),
    .timeout_count (tcnt_a)
  );

  rggen_bus_splitter_ex #(
    .DATA_WIDTH         (32),
    .TOTAL_REGISTERS    (3),
    .TIMEOUT_CYCLES     (0),
    .CHECK_MULTI_SELECT (0)
  ) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_if        (bus_b),
    .register_if   (reg_b),
    .timeout_count (tcnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    req   = 1'b0;
    addr  = '0;
    dir   = RGGEN_READ;
    wdata = '0;
    wstrb = '0;
    sel   = '0;
    rdy   = '0;
    rdata = '0;
    stat  = '0;

    // Reset values.
    tick();
    check("rst_done_a",   bus_a.done,      1'b0);
    check("rst_rdata_a",  bus_a.read_data, 32'h0);
    check("rst_status_a", bus_a.status,    RGGEN_OKAY);
    check("rst_count_a",  tcnt_a,          3'd0);
    check("rst_done_b",   bus_b.done,      1'b0);
    check("rst_req_a",    req_a,           3'b000);
    rst_n = 1'b1;
    tick();

    // Zero-wait read from reg[2].
    addr = 16'h0008; dir = RGGEN_READ; sel = 3'b100; rdy = 3'b100;
    rdata[2] = 32'hA5A5_0001; req = 1'b1;
    #1;
    check("zw_req_fanout", req_a,      3'b111);
    check("zw_addr_bcast", addr_a1,    16'h0008);
    check("zw_done_early", bus_a.done, 1'b0);
    tick();
    check("zw_done_a",     bus_a.done,      1'b1);
    check("zw_rdata_a",    bus_a.read_data, 32'hA5A5_0001);
    check("zw_status_a",   bus_a.status,    RGGEN_OKAY);
    check("zw_req_in_rsp", req_a,           3'b000);
    check("zw_rdata_b",    bus_b.read_data, 32'hA5A5_0001);
    req = 1'b0;
    tick();
    check("zw_idle_done",  bus_a.done,      1'b0);
    check("zw_idle_rdata", bus_a.read_data, 32'h0);

    // Write to reg[1]: read_data must come back zero.
    addr = 16'h0004; dir = RGGEN_WRITE; wdata = 32'h1234_5678; wstrb = 4'b0101;
    sel = 3'b010; rdy = 3'b010; rdata[1] = 32'hDEAD_BEEF; req = 1'b1;
    #1;
    check("wr_wdata_bcast", wdata_a2, 32'h1234_5678);
    check("wr_wstrb_bcast", wstrb_a2, 4'b0101);
    check("wr_dir_bcast",   dir_a0,   RGGEN_WRITE);
    tick();
    check("wr_done_a",   bus_a.done,      1'b1);
    check("wr_rdata_a",  bus_a.read_data, 32'h0);
    check("wr_status_a", bus_a.status,    RGGEN_OKAY);
    req = 1'b0;
    tick();

    // No select: decode error.
    addr = 16'h0100; sel = 3'b000; rdy = 3'b111; req = 1'b1;
    tick();
    check("ns_done_a",   bus_a.done,      1'b1);
    check("ns_status_a", bus_a.status,    RGGEN_DECODE_ERROR);
    check("ns_rdata_a",  bus_a.read_data, 32'h0);
    check("ns_status_b", bus_b.status,    RGGEN_DECODE_ERROR);
    req = 1'b0;
    tick();

    // Multi-select of reg[0] and reg[1].
    dir = RGGEN_READ; addr = 16'h0000; sel = 3'b011; rdy = 3'b011;
    rdata[0] = 32'h0000_00F0; rdata[1] = 32'h0000_0F00; req = 1'b1;
    tick();
    check("ms_done_a",   bus_a.done,      1'b1);
    check("ms_status_a", bus_a.status,    RGGEN_SLAVE_ERROR);
    check("ms_rdata_a",  bus_a.read_data, 32'h0);
    check("ms_done_b",   bus_b.done,      1'b1);
    check("ms_rdata_b",  bus_b.read_data, 32'h0000_0FF0);
    check("ms_status_b", bus_b.status,    RGGEN_OKAY);
    req = 1'b0;
    tick();

    // Register-reported slave error passes its data through.
    sel = 3'b001; rdy = 3'b001; rdata[0] = 32'h0000_0055; stat[0] = RGGEN_SLAVE_ERROR; req = 1'b1;
    tick();
    check("se_rdata_a",  bus_a.read_data, 32'h0000_0055);
    check("se_status_a", bus_a.status,    RGGEN_SLAVE_ERROR);
    req = 1'b0; stat[0] = RGGEN_OKAY;
    tick();

    // Timeout on reg[2] held not ready (dut_b stalls).
    sel = 3'b100; rdy = 3'b000; rdata[2] = 32'h0000_0077; req = 1'b1;
    #1;
    check("to_count0", tcnt_a,     3'd0);
    check("to_done0",  bus_a.done, 1'b0);
    tick();
    check("to_count1", tcnt_a,   3'd1);
    check("to_req1",   req_a[2], 1'b1);
    tick();
    check("to_count2", tcnt_a, 3'd2);
    tick();
    check("to_count3", tcnt_a,     3'd3);
    check("to_done3",  bus_a.done, 1'b0);
    tick();
    check("to_done_a",   bus_a.done,      1'b1);
    check("to_status_a", bus_a.status,    RGGEN_SLAVE_ERROR);
    check("to_rdata_a",  bus_a.read_data, 32'h0);
    check("to_req_rsp",  req_a[2],        1'b0);
    check("to_count_rsp", tcnt_a,         3'd0);
    check("stall_done_b", bus_b.done,     1'b0);
    check("stall_cnt_b",  tcnt_b,         1'b0);
    check("stall_req_b",  req_b[2],       1'b1);
    req = 1'b0;
    tick();
    check("to_after_a",  bus_a.done, 1'b0);
    check("stall_abn_b", bus_b.done, 1'b0);

    // Request dropped before completion: abandoned.
    sel = 3'b001; rdy = 3'b000; req = 1'b1;
    tick();
    tick();
    check("ab_count2", tcnt_a, 3'd2);
    req = 1'b0;
    tick();
    check("ab_count_clr", tcnt_a,     3'd0);
    check("ab_no_done",   bus_a.done, 1'b0);
    tick();
    check("ab_no_done2",  bus_a.done, 1'b0);

    // Reset mid-wait at count 2.
    sel = 3'b010; rdy = 3'b000; req = 1'b1;
    tick();
    tick();
    check("rw_count2", tcnt_a, 3'd2);
    rst_n = 1'b0;
    #1;
    check("rw_count_rst",  tcnt_a,          3'd0);
    check("rw_done_rst",   bus_a.done,      1'b0);
    check("rw_status_rst", bus_a.status,    RGGEN_OKAY);
    check("rw_rdata_rst",  bus_a.read_data, 32'h0);
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rw_no_done_a", bus_a.done, 1'b0);
    check("rw_no_done_b", bus_b.done, 1'b0);

    // Back-to-back: request held high gives one done per access.
    sel = 3'b100; rdy = 3'b100; rdata[2] = 32'h1111_2222; req = 1'b1;
    tick();
    check("bb_done1",  bus_a.done,      1'b1);
    check("bb_rdata1", bus_a.read_data, 32'h1111_2222);
    tick();
    check("bb_gap_done",  bus_a.done,      1'b0);
    check("bb_gap_rdata", bus_a.read_data, 32'h0);
    check("bb_gap_req",   req_a[2],        1'b1);
    tick();
    check("bb_done2",   bus_a.done,      1'b1);
    check("bb_rdata2",  bus_a.read_data, 32'h1111_2222);
    check("bb_done2_b", bus_b.done,      1'b1);
    req = 1'b0;
    tick();
    check("bb_end_done", bus_a.done, 1'b0);
    tick();
    check("bb_end_done2", bus_a.done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the sequence ever stops advancing.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of sequence, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rggen_bus_splitter_ex.md
RGGEN_BUS_SPLITTER_EX -- requirements
Module: rggen_bus_splitter_ex

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bus and register data width in bits, multiple of 8.
REQ-002 Parameter TOTAL_REGISTERS, default 1: number of register_if channels, at least 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 0: wait-cycle limit per access; 0 disables the timeout.
REQ-004 Parameter CHECK_MULTI_SELECT, default 1: 1 enables the error response on multiple simultaneous selects.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port bus_if, rggen_bus_if.slave: upstream request, address, direction, write_data, write_strobe, done, read_data, status.
REQ-008 Port register_if[TOTAL_REGISTERS], rggen_register_if.master: fan-out request/address/direction/write_data/write_strobe; fan-in select, ready, read_data, status.
REQ-009 Port timeout_count, output, CW bits (CW = clog2(TIMEOUT_CYCLES+1), minimum 1): current wait count, for debug only.

Function
REQ-010 The block SHALL use a two-state FSM: ACCESS (reset state) and RESPONSE.
REQ-011 In ACCESS, every register_if.request SHALL equal bus_if.request; in RESPONSE, every register_if.request SHALL be 0.
REQ-012 Address, direction, write_data and write_strobe SHALL be broadcast to all channels unmodified at all times.
REQ-013 In ACCESS with bus_if.request=1, the access completes when any of these holds: (a) no select; (b) more than one select and CHECK_MULTI_SELECT=1; (c) the OR of ready over selected channels is 1; (d) TIMEOUT_CYCLES>0 and timeout_count equals TIMEOUT_CYCLES-1.
REQ-014 On completion, the FSM SHALL move to RESPONSE and register the response; bus_if.done SHALL be 1 exactly during the RESPONSE cycle, which returns unconditionally to ACCESS.
REQ-015 A zero-wait register SHALL produce done one cycle after request rises; N wait cycles add N.
REQ-016 Response priority SHALL be: (a) status RGGEN_DECODE_ERROR, read_data 0; then (b) RGGEN_SLAVE_ERROR, read_data 0; then (c) the selected read_data/status via one-hot OR-mux; then (d) timeout, RGGEN_SLAVE_ERROR, read_data 0.
REQ-017 On a write completion, read_data SHALL be 0 regardless of the register's read_data.
REQ-018 Outside RESPONSE, bus_if.read_data SHALL be 0 and bus_if.status SHALL be RGGEN_OKAY.
REQ-019 timeout_count SHALL increment each ACCESS cycle with request=1 and no completion; it SHALL clear on completion, on request=0, and in RESPONSE; it never wraps.
REQ-020 With TIMEOUT_CYCLES=0, timeout_count SHALL stay 0 and a non-ready register SHALL stall indefinitely.
REQ-021 If request drops in ACCESS before completion (protocol violation), the block SHALL abandon the access silently: no done, counter cleared.
REQ-022 Request held high in the cycle after RESPONSE SHALL be treated as a new access.

Reset
REQ-023 While rst_n=0: state=ACCESS, done=0, read_data=0, status=RGGEN_OKAY, timeout_count=0.
REQ-024 Reset asserted mid-access SHALL abort the access with no done pulse after release.

Structure
REQ-025 rggen_status and rggen_direction SHALL come from rggen_rtl_pkg; the FSM state enum SHALL stay local to the module.
REQ-026 The one-hot OR-mux SHALL be a sub-module rggen_or_mux (parameters WIDTH, ENTRIES), instantiated for read_data and status.
REQ-027 All registers SHALL be in a single clk/rst_n always_ff domain.

Verification
REQ-028 Zero-wait read: reg[2] select=1, ready=1, read_data=0xA5A5_0001, status OKAY -> done 1 cycle later, read_data=0xA5A5_0001, OKAY.
REQ-029 No select: write to an unmapped address -> done 1 cycle later, status DECODE_ERROR, read_data 0.
REQ-030 Multi-select: CHECK_MULTI_SELECT=1, reg[0] and reg[1] selected -> SLAVE_ERROR; with CHECK_MULTI_SELECT=0 -> the OR of both read_data values.
REQ-031 Timeout: TIMEOUT_CYCLES=4, ready held 0 -> timeout_count 0,1,2,3, done on the 5th cycle, SLAVE_ERROR; register request is 0 during the done cycle.
REQ-032 Reset mid-wait: rst_n pulsed low at timeout_count=2 -> all outputs at reset values and no spurious done; back-to-back requests yield one done per access.
